gb_mbc_sync: RTL and testbench



---
 rtl/gb_mbc_pkg.sv | 36 +++
 rtl/gb_bus_sync.sv | 99 +++++++++
 rtl/gb_mbc_sync.sv | 150 +++++++++++++++
 tb/tb_gb_mbc_sync.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/gb_mbc_pkg.sv
// rtl/gb_mbc_pkg.sv - shared constants and types for the Game Boy bank controller
//
// Purpose: mode selectors, register region nibbles (GB_A[15:12]), the RAM
// enable key, reset bank values and the committed bus-write record.
// Ports: none (package).
package gb_mbc_pkg;

  localparam int MODE_MBC5 = 0;
  localparam int MODE_MBC1 = 1;

  // Register regions, compared against captured GB_A[15:12]
  localparam logic [3:0] RGN_RAMEN = 4'h0;  // 0x0000-0x1FFF
  localparam logic [3:0] RGN_ROMLO = 4'h2;  // 0x2000 (MBC5 low byte, MBC1 lo5 with 0x3000)
  localparam logic [3:0] RGN_ROMHI = 4'h3;  // 0x3000 (MBC5 bank bit 8)
  localparam logic [3:0] RGN_RAMBK = 4'h4;  // 0x4000-0x5FFF
  localparam logic [3:0] RGN_BMODE = 4'h6;  // 0x6000-0x7FFF

  localparam logic [3:0] RAMEN_KEY = 4'hA;

  localparam int unsigned RST_ROM_BANK = 1;
  localparam int unsigned RST_RAM_BANK = 0;
  localparam logic [4:0]  RST_LO5      = 5'd1;
  localparam logic [1:0]  RST_HI2      = 2'd0;
  localparam logic        RST_BMODE    = 1'b0;

  typedef struct packed {
    logic [3:0] a;
    logic [7:0] d;
  } bus_wr_t;

  // True when the nibble falls in the 8 KiB region that starts at rgn
  function automatic logic in_region(input logic [3:0] a, input logic [3:0] rgn);
    return a[3:1] == rgn[3:1];
  endfunction

endpackage

// File: rtl/gb_bus_sync.sv
// rtl/gb_bus_sync.sv - bus synchroniser, write glitch filter and commit pulse
//
// Purpose: brings GB /WR, /RD, A[15:12], D[7:0] into the CLK domain, accepts
// a write only after two consecutive low synchronised /WR cycles with /RD
// high, keeps capturing address/data while the write stays qualified and
// emits a one-cycle commit on the synchronised /WR rising edge.
// Ports:
//   clk_i, rst_ni       clock, asynchronous active-low reset
//   wr_ni, rd_ni        raw /WR and /RD pins
//   a_i, d_i            raw address nibble and data bus
//   commit_o            one-cycle pulse: apply wr_o this cycle
//   wr_o                last captured address/data
module gb_bus_sync
  import gb_mbc_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       wr_ni,
  input  logic       rd_ni,
  input  logic [3:0] a_i,
  input  logic [7:0] d_i,
  output logic       commit_o,
  output bus_wr_t    wr_o
);

  localparam int SW = 14;
  // /WR resets low so a write already in progress across reset can never
  // look like a fresh falling edge; seen_high_q then gates qualification.
  localparam logic [SW-1:0] SYNC_RST = {1'b0, 1'b1, 12'h000};

  logic [SW-1:0] sync_q [SYNC_STAGES];
  logic [SW-1:0] sync_out;
  logic          wr_s;
  logic          rd_s;
  bus_wr_t       bus_s;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= SYNC_RST;
    end else begin
      sync_q[0] <= {wr_ni, rd_ni, a_i, d_i};
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign sync_out = sync_q[SYNC_STAGES-1];
  assign wr_s     = sync_out[13];
  assign rd_s     = sync_out[12];
  assign bus_s    = sync_out[11:0];

  logic    low_q, low_d;
  logic    seen_high_q, seen_high_d;
  logic    armed_q, armed_d;
  logic    wr_prev_q, wr_prev_d;
  bus_wr_t cap_q, cap_d;
  logic    qual;
  logic    rise;

  always_comb begin
    // second (or later) consecutive low cycle with /RD idle
    qual        = !wr_s && rd_s && low_q && seen_high_q;
    rise        = wr_s && !wr_prev_q;
    low_d       = !wr_s && rd_s;
    seen_high_d = seen_high_q | wr_s;
    wr_prev_d   = wr_s;
    cap_d       = qual ? bus_s : cap_q;
    armed_d     = armed_q;
    if (rise) begin
      armed_d = 1'b0;
    end else if (!wr_s && !rd_s) begin
      armed_d = 1'b0;  // /WR and /RD together: bus contention, drop it
    end else if (qual) begin
      armed_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      low_q       <= 1'b0;
      seen_high_q <= 1'b0;
      armed_q     <= 1'b0;
      wr_prev_q   <= 1'b0;
      cap_q       <= '0;
    end else begin
      low_q       <= low_d;
      seen_high_q <= seen_high_d;
      armed_q     <= armed_d;
      wr_prev_q   <= wr_prev_d;
      cap_q       <= cap_d;
    end
  end

  // Combinational from flops so registers update SYNC_STAGES + 1 edges after the pin rises
  assign commit_o = rise && armed_q;
  assign wr_o     = cap_q;

endmodule

// File: rtl/gb_mbc_sync.sv
// rtl/gb_mbc_sync.sv - clocked MBC5/MBC1 bank controller for the GB cartridge
//
// Purpose: decodes committed bus writes into bank/enable registers and maps
// them onto ROM/RAM high address lines; chip selects and level-shifter
// direction are combinational from the raw pins.
// Ports:
//   CLK, RST_N          clock, asynchronous active-low reset
//   GB_A, GB_D          cartridge address [15:12] and data bus
//   GB_CS, GB_WR, GB_RD cartridge strobes, active low
//   ROM_A, RAM_A        ROM [ROM_BANK_W+13:14] / RAM [RAM_BANK_W+12:13] address
//   ROM_CS, RAM_CS      chip selects, active low
//   DDIR                level shifter direction, 1 = cart->GB
//   RAM_EN_O            RAM enable state
module gb_mbc_sync
  import gb_mbc_pkg::*;
#(
  parameter int MODE        = 0,
  parameter int ROM_BANK_W  = 9,
  parameter int RAM_BANK_W  = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic [3:0]            GB_A,
  input  logic [7:0]            GB_D,
  input  logic                  GB_CS,
  input  logic                  GB_WR,
  input  logic                  GB_RD,
  output logic [ROM_BANK_W-1:0] ROM_A,
  output logic [RAM_BANK_W-1:0] RAM_A,
  output logic                  ROM_CS,
  output logic                  RAM_CS,
  output logic                  DDIR,
  output logic                  RAM_EN_O
);

  logic    commit;
  bus_wr_t cmt;
  logic    cmt_reg;

  gb_bus_sync #(.SYNC_STAGES(SYNC_STAGES)) u_bus_sync (
    .clk_i    (CLK),
    .rst_ni   (RST_N),
    .wr_ni    (GB_WR),
    .rd_ni    (GB_RD),
    .a_i      (GB_A),
    .d_i      (GB_D),
    .commit_o (commit),
    .wr_o     (cmt)
  );

  // Only the 0x0000-0x7FFF space holds registers
  assign cmt_reg = commit && !cmt.a[3];

  logic ram_en_q, ram_en_d;

  always_comb begin
    ram_en_d = ram_en_q;
    if (cmt_reg && in_region(cmt.a, RGN_RAMEN)) ram_en_d = (cmt.d[3:0] == RAMEN_KEY);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) ram_en_q <= 1'b0;
    else        ram_en_q <= ram_en_d;
  end

  logic [ROM_BANK_W-1:0] rom_lo_bank;
  logic [ROM_BANK_W-1:0] rom_hi_bank;
  logic [RAM_BANK_W-1:0] ram_bank;

  generate
    if (MODE == MODE_MBC1) begin : g_mbc1
      logic [4:0] lo5_q, lo5_d;
      logic [1:0] hi2_q, hi2_d;
      logic       bmode_q, bmode_d;

      always_comb begin
        lo5_d   = lo5_q;
        hi2_d   = hi2_q;
        bmode_d = bmode_q;
        if (cmt_reg) begin
          // bank 0 cannot be selected into the upper window
          if (in_region(cmt.a, RGN_ROMLO)) lo5_d = (cmt.d[4:0] == 5'd0) ? 5'd1 : cmt.d[4:0];
          if (in_region(cmt.a, RGN_RAMBK)) hi2_d = cmt.d[1:0];
          if (in_region(cmt.a, RGN_BMODE)) bmode_d = cmt.d[0];
        end
      end

      always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
          lo5_q   <= RST_LO5;
          hi2_q   <= RST_HI2;
          bmode_q <= RST_BMODE;
        end else begin
          lo5_q   <= lo5_d;
          hi2_q   <= hi2_d;
          bmode_q <= bmode_d;
        end
      end

      assign rom_hi_bank = ROM_BANK_W'({hi2_q, lo5_q});
      assign rom_lo_bank = bmode_q ? ROM_BANK_W'({hi2_q, 5'b0}) : '0;
      assign ram_bank    = bmode_q ? RAM_BANK_W'(hi2_q) : '0;
    end else begin : g_mbc5
      // Working copy wide enough to hold bit 8 even for narrow flash parts
      localparam int RW = (ROM_BANK_W > 9) ? ROM_BANK_W : 9;

      logic [ROM_BANK_W-1:0] rom_bank_q, rom_bank_d;
      logic [RAM_BANK_W-1:0] ram_bank_q, ram_bank_d;
      logic [RW-1:0]         bank_ext;

      always_comb begin
        bank_ext   = RW'(rom_bank_q);
        ram_bank_d = ram_bank_q;
        if (cmt_reg && (cmt.a == RGN_ROMLO)) bank_ext[7:0] = cmt.d;
        if (cmt_reg && (cmt.a == RGN_ROMHI)) bank_ext[8] = cmt.d[0];
        if (cmt_reg && in_region(cmt.a, RGN_RAMBK)) ram_bank_d = RAM_BANK_W'(cmt.d);
        rom_bank_d = bank_ext[ROM_BANK_W-1:0];
      end

      always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
          rom_bank_q <= ROM_BANK_W'(RST_ROM_BANK);
          ram_bank_q <= RAM_BANK_W'(RST_RAM_BANK);
        end else begin
          rom_bank_q <= rom_bank_d;
          ram_bank_q <= ram_bank_d;
        end
      end

      assign rom_hi_bank = rom_bank_q;
      assign rom_lo_bank = '0;
      assign ram_bank    = ram_bank_q;
    end
  endgenerate

  logic rom_lo, rom_hit, ram_hit;

  assign rom_lo   = (GB_A[3:2] == 2'b00);
  assign rom_hit  = !GB_A[3];
  assign ram_hit  = (GB_A[3:1] == 3'b101);

  assign ROM_CS   = !(rom_hit && RST_N);
  assign RAM_CS   = !(ram_hit && ram_en_q && !GB_CS && RST_N);
  assign DDIR     = (!ROM_CS || !RAM_CS) && !GB_RD;
  assign ROM_A    = rom_lo ? rom_lo_bank : rom_hi_bank;
  assign RAM_A    = ram_bank;
  assign RAM_EN_O = ram_en_q;

endmodule

// File: tb/tb_gb_mbc_sync.sv
// tb/tb_gb_mbc_sync.sv - self-checking bench for both MBC5 and MBC1 builds
module tb_gb_mbc_sync;

  localparam int SYNC = 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] gb_a;
  logic [7:0] gb_d;
  logic       gb_cs, gb_wr, gb_rd;

  logic [8:0] rom_a5, rom_a1;
  logic [3:0] ram_a5, ram_a1;
  logic       rom_cs5, rom_cs1, ram_cs5, ram_cs1, ddir5, ddir1, ram_en5, ram_en1;

  always #5 clk = ~clk;

  gb_mbc_sync #(.MODE(0), .ROM_BANK_W(9), .RAM_BANK_W(4), .SYNC_STAGES(SYNC)) u_mbc5 (
    .CLK(clk), .RST_N(rst_n), .GB_A(gb_a), .GB_D(gb_d), .GB_CS(gb_cs), .GB_WR(gb_wr),
    .GB_RD(gb_rd), .ROM_A(rom_a5), .RAM_A(ram_a5), .ROM_CS(rom_cs5), .RAM_CS(ram_cs5),
    .DDIR(ddir5), .RAM_EN_O(ram_en5)
  );

  gb_mbc_sync #(.MODE(1), .ROM_BANK_W(9), .RAM_BANK_W(4), .SYNC_STAGES(SYNC)) u_mbc1 (
    .CLK(clk), .RST_N(rst_n), .GB_A(gb_a), .GB_D(gb_d), .GB_CS(gb_cs), .GB_WR(gb_wr),
    .GB_RD(gb_rd), .ROM_A(rom_a1), .RAM_A(ram_a1), .ROM_CS(rom_cs1), .RAM_CS(ram_cs1),
    .DDIR(ddir1), .RAM_EN_O(ram_en1)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: register contents as plain numbers
  int m5_rom, m5_ram, m1_lo5, m1_hi2, m1_bmode;
  bit m_en;

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic model_reset();
    m5_rom = 1; m5_ram = 0; m_en = 0;
    m1_lo5 = 1; m1_hi2 = 0; m1_bmode = 0;
  endtask

  task automatic model_write(input int a, input int d);
    if (a >= 8) return;
    if (a < 2) m_en = ((d % 16) == 10);
    if (a == 2) m5_rom = (m5_rom / 256) * 256 + d;
    if (a == 3) m5_rom = (m5_rom % 256) + (d % 2) * 256;
    if (a == 4 || a == 5) m5_ram = d % 16;
    if (a == 2 || a == 3) m1_lo5 = ((d % 32) == 0) ? 1 : d % 32;
    if (a == 4 || a == 5) m1_hi2 = d % 4;
    if (a == 6 || a == 7) m1_bmode = d % 2;
  endtask

  task automatic check_outputs(input string tag);
    int a;
    bit rom_cs_e, ram_cs_e, ddir_e;
    a        = int'(gb_a);
    rom_cs_e = !(a < 8 && rst_n);
    ram_cs_e = !((a == 10 || a == 11) && m_en && !gb_cs && rst_n);
    ddir_e   = (!rom_cs_e || !ram_cs_e) && !gb_rd;
    check({tag, "/rom_cs5"}, rom_cs5, rom_cs_e);
    check({tag, "/rom_cs1"}, rom_cs1, rom_cs_e);
    check({tag, "/ram_cs5"}, ram_cs5, ram_cs_e);
    check({tag, "/ram_cs1"}, ram_cs1, ram_cs_e);
    check({tag, "/ddir5"}, ddir5, ddir_e);
    check({tag, "/ddir1"}, ddir1, ddir_e);
    check({tag, "/ram_en5"}, ram_en5, m_en);
    check({tag, "/ram_en1"}, ram_en1, m_en);
    check({tag, "/rom_a5"}, rom_a5, (a < 4) ? 0 : m5_rom);
    check({tag, "/rom_a1"}, rom_a1,
          (a < 4) ? (m1_bmode ? m1_hi2 * 32 : 0) : m1_hi2 * 32 + m1_lo5);
    check({tag, "/ram_a5"}, ram_a5, m5_ram);
    check({tag, "/ram_a1"}, ram_a1, m1_bmode ? m1_hi2 : 0);
  endtask

  task automatic probe(input string tag, input int a, input bit rd, input bit cs);
    @(negedge clk);
    gb_a = 4'(a); gb_rd = rd; gb_cs = cs;
    #1;
    check_outputs(tag);
  endtask

  // Drive one write; low = pin /WR low cycles; rd_ovl holds /RD low with it.
  // Checks the outputs one edge before and exactly at the expected update edge.
  task automatic bus_write(input int a, input int d, input int low, input bit rd_ovl);
    bit commits;
    commits = (low >= 2) && !rd_ovl;
    @(negedge clk);
    gb_a = 4'(a); gb_d = 8'(d); gb_rd = !rd_ovl; gb_cs = 1'b1; gb_wr = 1'b0;
    repeat (low) @(negedge clk);
    gb_wr = 1'b1; gb_rd = 1'b1;
    gb_a  = 4'(4 + $urandom_range(0, 3));
    repeat (SYNC) @(posedge clk);
    @(negedge clk);
    check_outputs("pre_update");
    @(posedge clk);
    @(negedge clk);
    if (commits) model_write(a, d);
    check_outputs("post_update");
  endtask

  initial begin
    int a, d, kind;
    model_reset();
    rst_n = 1'b0; gb_a = 4'h4; gb_d = 8'h00; gb_cs = 1'b1; gb_wr = 1'b1; gb_rd = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check_outputs("in_reset");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    probe("rst_upper", 4, 1'b0, 1'b1);
    check("rst_upper_rom_a", rom_a5, 1);
    check("rst_upper_ddir", ddir5, 1);
    probe("rst_lower", 0, 1'b0, 1'b1);
    check("rst_lower_rom_a", rom_a5, 0);

    // MBC5 ROM bank
    bus_write(2, 'h5A, 3, 1'b0);
    bus_write(3, 'h01, 2, 1'b0);
    probe("mbc5_bank", 5, 1'b1, 1'b1);
    check("mbc5_bank_15a", rom_a5, 'h15A);
    bus_write(3, 'h00, 2, 1'b0);
    bus_write(2, 'h00, 2, 1'b0);
    probe("mbc5_bank0", 4, 1'b0, 1'b1);
    check("mbc5_bank0_rom_a", rom_a5, 0);

    // MBC5 RAM
    bus_write(0, 'h0A, 2, 1'b0);
    bus_write(4, 'h07, 2, 1'b0);
    probe("mbc5_ram", 'hA, 1'b0, 1'b0);
    check("mbc5_ram_cs", ram_cs5, 0);
    check("mbc5_ram_a", ram_a5, 7);
    bus_write(0, 'h00, 2, 1'b0);
    probe("mbc5_ram_off", 'hB, 1'b0, 1'b0);
    check("mbc5_ram_off_cs", ram_cs5, 1);

    // MBC1 mapping
    bus_write(2, 'h00, 2, 1'b0);
    bus_write(4, 'h02, 2, 1'b0);
    bus_write(6, 'h01, 2, 1'b0);
    probe("mbc1_lower", 1, 1'b0, 1'b1);
    check("mbc1_lower_40", rom_a1, 'h40);
    probe("mbc1_upper", 6, 1'b0, 1'b1);
    check("mbc1_upper_41", rom_a1, 'h41);
    check("mbc1_ram_a", ram_a1, 2);

    // Glitch and bus contention must not commit
    bus_write(2, 'h33, 1, 1'b0);
    bus_write(2, 'h44, 3, 1'b1);
    check("glitch_rom_a1", rom_a1, 'h41);

    // Randomised traffic
    for (int i = 0; i < 60; i++) begin
      a    = ($urandom_range(0, 3) == 0) ? $urandom_range(8, 15) : $urandom_range(0, 7);
      d    = $urandom_range(0, 255);
      if (a < 2 && $urandom_range(0, 1) == 1) d = (d & 'hF0) | 'hA;
      kind = $urandom_range(0, 5);
      if (kind == 0)      bus_write(a, d, 1, 1'b0);
      else if (kind == 1) bus_write(a, d, 3, 1'b1);
      else                bus_write(a, d, $urandom_range(2, 4), 1'b0);
      probe("rand_read", $urandom_range(0, 15), 1'(($urandom_range(0, 1))),
            1'(($urandom_range(0, 1))));
    end

    // Reset in the middle of a write
    bus_write(2, 'h77, 2, 1'b0);
    bus_write(0, 'h0A, 2, 1'b0);
    @(negedge clk);
    gb_a = 4'h2; gb_d = 8'h13; gb_wr = 1'b0; gb_rd = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    gb_rd = 1'b0;
    model_reset();
    #1;
    check_outputs("mid_reset");
    check("mid_reset_ddir", ddir5, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1; gb_rd = 1'b1;
    repeat (3) @(negedge clk);
    gb_wr = 1'b1;
    repeat (SYNC + 3) @(negedge clk);
    probe("after_reset", 4, 1'b0, 1'b1);
    check("after_reset_rom_a5", rom_a5, 1);
    check("after_reset_rom_a1", rom_a1, 1);
    check("after_reset_ram_en", ram_en5, 0);

    // A normal write still works afterwards
    bus_write(2, 'h21, 2, 1'b0);
    check("post_reset_write", rom_a5, 'h21);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
